// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one column per clock through a shared column datapath.
// Accepts a 128-bit state in IDLE, spends 4 BUSY cycles, then presents the result in DONE.
module inv_mix_columns_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_q, state_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic [127:0] cap_q, cap_d;
  logic [127:0] res_q, res_d;

  logic [31:0]  col_in;
  logic [31:0]  col_out;
  logic [7:0]   b  [4];
  logic [7:0]   x2 [4];
  logic [7:0]   x4 [4];
  logic [7:0]   x8 [4];
  logic [7:0]   m9 [4];
  logic [7:0]   mb [4];
  logic [7:0]   md [4];
  logic [7:0]   me [4];
  logic [7:0]   d  [4];

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    case (col_cnt_q)
      2'd0:    col_in = cap_q[127:96];
      2'd1:    col_in = cap_q[95:64];
      2'd2:    col_in = cap_q[63:32];
      default: col_in = cap_q[31:0];
    endcase
  end

  // Each output byte i sums 0e*b[i], 0b*b[i+1], 0d*b[i+2], 09*b[i+3] (indices mod 4).
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign b[gi]  = col_in[31-8*gi -: 8];
    assign x2[gi] = xtime(b[gi]);
    assign x4[gi] = xtime(x2[gi]);
    assign x8[gi] = xtime(x4[gi]);
    assign m9[gi] = x8[gi] ^ b[gi];
    assign mb[gi] = x8[gi] ^ x2[gi] ^ b[gi];
    assign md[gi] = x8[gi] ^ x4[gi] ^ b[gi];
    assign me[gi] = x8[gi] ^ x4[gi] ^ x2[gi];
    assign d[gi]  = me[gi] ^ mb[(gi+1)%4] ^ md[(gi+2)%4] ^ m9[(gi+3)%4];
  end

  assign col_out   = {d[0], d[1], d[2], d[3]};
  assign out_state = res_q;

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    cap_d     = cap_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cap_d     = in_state;
          col_cnt_d = 2'd0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        case (col_cnt_q)
          2'd0:    res_d[127:96] = col_out;
          2'd1:    res_d[95:64]  = col_out;
          2'd2:    res_d[63:32]  = col_out;
          default: res_d[31:0]   = col_out;
        endcase
        col_cnt_d = col_cnt_q + 2'd1;
        if (col_cnt_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      col_cnt_q <= 2'd0;
      cap_q     <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      cap_q     <= cap_d;
      res_q     <= res_d;
    end
  end

endmodule

// File: doc/inv_mix_columns_iter.md
INV_MIX_COLUMNS_ITER -- requirements
Module: inv_mix_columns_iter

Interface
REQ-001 The block SHALL have no parameters; the width is fixed at 128-bit state, 4 columns of 4 bytes.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  the source presents a state on in_state.
REQ-006 in_ready  output  1  the block can accept a state.
REQ-007 in_state  input  128  state to transform; byte k = in_state[127-8k -: 8], k=0..15; column c = bytes 4c..4c+3, row 0 first.
REQ-008 out_valid  output  1  out_state holds a completed result.
REQ-009 out_ready  input  1  the sink accepts out_state.
REQ-010 out_state  output  128  InvMixColumns result, with the same byte ordering as in_state.
REQ-011 busy  output  1  high in the BUSY state.

Function
REQ-012 The block SHALL implement an FSM with the states IDLE, BUSY and DONE.
REQ-013 IDLE: in_ready=1, out_valid=0; when in_valid=1, capture in_state into the internal state register, clear col_cnt (2 bits) to 0, and go to BUSY.
REQ-014 BUSY: in_ready=0; each cycle transform column col_cnt of the captured state and write the 4 result bytes into the same column of the result register; col_cnt increments.
REQ-015 BUSY to DONE: occurs on the cycle col_cnt==3 is processed; col_cnt wraps to 0.
REQ-016 DONE: out_valid=1, in_ready=0; out_state stays stable until out_valid&&out_ready, then go to IDLE.
REQ-017 DONE hold: while out_ready=0, the block SHALL hold out_state, out_valid and the state indefinitely, with no timeout.
REQ-018 Latency: the accept edge is cycle 0; out_valid is first high after the edge at cycle 4, so exactly 4 clocks after acceptance.
REQ-019 Throughput: at most one state per 6 cycles with out_ready tied high (accept, 4 BUSY, 1 DONE); no accept in the same cycle as the output handshake.
REQ-020 Column math over GF(2^8) with polynomial x^8+x^4+x^3+x+1 (0x11B):
  - d0 = 0e*b0 ^ 0b*b1 ^ 0d*b2 ^ 09*b3
  - d1 = 09*b0 ^ 0e*b1 ^ 0b*b2 ^ 0d*b3
  - d2 = 0d*b0 ^ 09*b1 ^ 0e*b2 ^ 0b*b3
  - d3 = 0b*b0 ^ 0d*b1 ^ 09*b2 ^ 0e*b3
REQ-021 Multiplication structure: the constant multiplies SHALL be built from xtime (shift left, conditional XOR 0x1B), so that one column datapath serves all 4 columns.
REQ-022 Input gating: in_state and in_valid SHALL be ignored outside IDLE; changes to in_state after acceptance SHALL NOT affect the result.
REQ-023 Unwritten columns: result-register columns not yet written in BUSY are don't-care internally; out_state is only defined while out_valid=1.
REQ-024 Inverse property: for any 128-bit X, out_state SHALL equal X when in_state = MixColumns(X).

Reset
REQ-025 Reset values when rst=1 at a clock edge:
  - FSM goes to IDLE, col_cnt=0
  - out_valid=0, busy=0, in_ready=1 after the edge
  - out_state=128'h0
REQ-026 Reset mid-operation: reset asserted in BUSY or DONE SHALL abort the transform; the partial result is discarded and no out_valid pulse follows.
REQ-027 Reset priority: reset SHALL take priority over a simultaneous in_valid or out_ready.

Verification
REQ-028 Known vector: in_state=8e4da1bc9fdc589d01010101d5d5d7d6, out_ready=1 -> out_valid high 4 clocks after the accept edge, out_state=db135345f20a225c01010101d4d4d4d5.
REQ-029 Fixed points: in_state=01010101c6c6c6c6 repeated twice -> out_state equals in_state; in_state=0 -> out_state=0.
REQ-030 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_state stable, in_ready=0, a new in_valid is not accepted; then out_ready=1 -> one handshake, IDLE next cycle.
REQ-031 Reset in BUSY after 2 columns -> out_valid=0, out_state=0, in_ready=1 the next cycle; a following vector from REQ-028 produces the correct result.
REQ-032 Round trip: 1000 random X fed through the team's MixColumns block then this block -> out_state==X; also check in_state changed during BUSY does not alter the result.
